// File: rtl/shd_pkg.sv
// Shared types and sizing helpers for the SHD window sequencer.
// Also used by the aggregator to agree on start-up latency.
package shd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } state_e;

  localparam int unsigned CLR_CYC = 2;

  function automatic int unsigned lat_f(
    input int unsigned wh,
    input int unsigned m
  );
    return ((wh - 1) * m + (wh - 1)) / 2 + 4;
  endfunction

  function automatic int unsigned cw_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shd_raster_counter.sv
// Raster (x,y) position counter with x wrapping at M-1.
// last_o flags the final pixel (M-1,N-1) of a frame.
module shd_raster_counter
  import shd_pkg::*;
#(
  parameter int unsigned M = 650,
  parameter int unsigned N = 480,
  localparam int unsigned XW = cw_f(M),
  localparam int unsigned YW = cw_f(N)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam logic [XW-1:0] XMAX = XW'(M - 1);
  localparam logic [YW-1:0] YMAX = YW'(N - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/shd_window_ctrl.sv
// Frame sequencer for the sliding-window SHD aggregator:
// clear, stream, flush, and output coordinate tracking.
module shd_window_ctrl
  import shd_pkg::*;
#(
  parameter int unsigned WC = 7,
  parameter int unsigned WH = 13,
  parameter int unsigned M  = 650,
  parameter int unsigned N  = 480,
  localparam int unsigned XW = cw_f(M),
  localparam int unsigned YW = cw_f(N)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_pix_valid,
  input  logic          i_pix_sof,
  output logic          o_pix_ready,
  output logic          o_win_dval,
  output logic          o_flush,
  output logic          o_agg_rstn,
  input  logic          i_agg_dval,
  output logic [XW-1:0] o_out_x,
  output logic [YW-1:0] o_out_y,
  output logic          o_out_inside,
  output logic          o_out_eof,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned LAT = lat_f(WH, M);
  localparam int unsigned CW  = cw_f(LAT + 5);
  localparam int unsigned H   = WH / 2;
  localparam logic [XW-1:0] XLO = XW'(H);
  localparam logic [XW-1:0] XHI = XW'(M - 1 - H);
  localparam logic [YW-1:0] YLO = YW'(H);
  localparam logic [YW-1:0] YHI = YW'(N - 1 - H);

  if (WH % 2 == 0 || WH < WC) begin : g_bad_cfg
    $error("shd_window_ctrl: WH must be odd and >= WC");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          agg_rstn_q, agg_rstn_d;
  logic          full_q, full_d;

  logic          xfer, in_last, out_en, out_last, clr;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;

  assign clr    = (state_q == CLEAR);
  assign xfer   = (state_q == STREAM) && i_pix_valid;
  assign out_en = i_agg_dval && !full_q;

  shd_raster_counter #(.M(M), .N(N)) u_in_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .en_i   (xfer),
    .clr_i  (clr),
    .x_o    (in_x),
    .y_o    (in_y),
    .last_o (in_last)
  );

  shd_raster_counter #(.M(M), .N(N)) u_out_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .en_i   (out_en),
    .clr_i  (clr),
    .x_o    (o_out_x),
    .y_o    (o_out_y),
    .last_o (out_last)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          err_d   = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cyc_q == CW'(CLR_CYC - 1)) state_d = STREAM;
      end
      STREAM: begin
        if (xfer && i_pix_sof && (in_x != '0 || in_y != '0))
          err_d = 1'b1;
        if (xfer && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if ((out_en && out_last) || full_q) begin
          state_d = DONE;
        end else if (cyc_q == CW'(LAT + 3)) begin
          // aggregator never delivered the full frame
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d      = (state_d != state_q) ? '0 : cyc_q + 1'b1;
    agg_rstn_d = (state_d != CLEAR);
    full_d     = full_q;
    if (clr) full_d = 1'b0;
    else if (out_en && out_last) full_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      agg_rstn_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      err_q      <= err_d;
      agg_rstn_q <= agg_rstn_d;
      full_q     <= full_d;
    end
  end

  assign o_pix_ready  = (state_q == STREAM);
  assign o_flush      = (state_q == FLUSH);
  assign o_win_dval   = xfer || o_flush;
  assign o_agg_rstn   = agg_rstn_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_err        = err_q;
  assign o_out_eof    = out_en && out_last;
  assign o_out_inside = out_en
                     && o_out_x >= XLO && o_out_x <= XHI
                     && o_out_y >= YLO && o_out_y <= YHI;

endmodule
